// File: rtl/rc_pkg.sv
// Shared route-compute definitions: port indices, one-hot port codes, routing modes,
// lookahead direction codes, skid-buffer states and the route result record.
// Pure declarations; no logic.
package rc_pkg;

   // Port indices into the 5-bit one-hot port vectors
   localparam int PORT_N    = 0;   // y+1
   localparam int PORT_E    = 1;   // x+1
   localparam int PORT_S    = 2;   // y-1
   localparam int PORT_W    = 3;   // x-1
   localparam int PORT_L    = 4;   // local ejection
   localparam int NUM_PORTS = 5;

   localparam logic [NUM_PORTS-1:0] OH_N = 5'b1 << PORT_N;
   localparam logic [NUM_PORTS-1:0] OH_E = 5'b1 << PORT_E;
   localparam logic [NUM_PORTS-1:0] OH_S = 5'b1 << PORT_S;
   localparam logic [NUM_PORTS-1:0] OH_W = 5'b1 << PORT_W;
   localparam logic [NUM_PORTS-1:0] OH_L = 5'b1 << PORT_L;

   // Dimension order
   localparam int MODE_XY = 0;
   localparam int MODE_YX = 1;

   // Lookahead direction codes on in_outdir
   localparam logic [1:0] DIR_N = 2'd0;
   localparam logic [1:0] DIR_E = 2'd1;
   localparam logic [1:0] DIR_S = 2'd2;
   localparam logic [1:0] DIR_W = 2'd3;

   // Skid buffer occupancy
   typedef enum logic [1:0] {
      BUF_EMPTY = 2'd0,
      BUF_ONE   = 2'd1,
      BUF_TWO   = 2'd2
   } buf_state_e;

   // One route decision
   typedef struct packed {
      logic                 err;
      logic [NUM_PORTS-1:0] alt;
      logic [NUM_PORTS-1:0] prefer;
   } route_t;

endpackage

// File: rtl/rc_compute.sv
// Purpose: dimension-ordered route decision (preferred + alternate port) for one destination.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the caller registers and flow-controls the result.
module rc_compute
   import rc_pkg::*;
#(
   parameter int MESH_X    = 4,
   parameter int MESH_Y    = 4,
   parameter int COORD_W   = 3,
   parameter int CURR_X    = 0,
   parameter int CURR_Y    = 0,
   parameter int MODE      = 0,
   parameter int LOOKAHEAD = 0
) (
   input  logic [2*COORD_W-1:0] dst,
   input  logic [1:0]           outdir,
   output route_t               route
);

   // Signed ints so a lookahead step off row/column 0 becomes -1 and is caught as off-mesh
   int dst_x;
   int dst_y;
   int ref_x;
   int ref_y;
   logic off_mesh;
   logic range_err;
   logic x_diff;
   logic y_diff;
   logic [NUM_PORTS-1:0] x_port;
   logic [NUM_PORTS-1:0] y_port;

   // Reference point, error detection and dimension-ordered port selection
   always_comb begin
      dst_x = int'(dst[COORD_W-1:0]);
      dst_y = int'(dst[2*COORD_W-1:COORD_W]);
      ref_x = CURR_X;
      ref_y = CURR_Y;
      if (LOOKAHEAD != 0) begin
         case (outdir)
            DIR_N:   ref_y = CURR_Y + 1;
            DIR_E:   ref_x = CURR_X + 1;
            DIR_S:   ref_y = CURR_Y - 1;
            default: ref_x = CURR_X - 1;
         endcase
      end

      off_mesh  = (ref_x < 0) || (ref_x >= MESH_X) || (ref_y < 0) || (ref_y >= MESH_Y);
      range_err = (dst_x >= MESH_X) || (dst_y >= MESH_Y);

      x_port = (dst_x > ref_x) ? OH_E : OH_W;
      y_port = (dst_y > ref_y) ? OH_N : OH_S;
      x_diff = (dst_x != ref_x);
      y_diff = (dst_y != ref_y);

      route = '0;
      if (off_mesh || range_err) begin
         route.err = 1'b1;
      end else if (!x_diff && !y_diff) begin
         route.prefer = OH_L;
      end else if (MODE == MODE_YX) begin
         route.prefer = y_diff ? y_port : x_port;
         route.alt    = (x_diff && y_diff) ? x_port : '0;
      end else begin
         route.prefer = x_diff ? x_port : y_port;
         route.alt    = (x_diff && y_diff) ? y_port : '0;
      end
   end

endmodule

// File: rtl/rc_pipe.sv
// Purpose: registered route-compute stage with a 2-entry skid buffer and error statistics.
// Latency: 1 cycle from acceptance to out_valid when the buffer is empty; 1 result/cycle sustained.
// Backpressure: in_ready is registered and drops only when both entries hold unconsumed results.
module rc_pipe
   import rc_pkg::*;
#(
   parameter int MESH_X    = 4,
   parameter int MESH_Y    = 4,
   parameter int COORD_W   = 3,
   parameter int CURR_X    = 0,
   parameter int CURR_Y    = 0,
   parameter int MODE      = 0,
   parameter int LOOKAHEAD = 0,
   parameter int TAG_W     = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*COORD_W-1:0] in_dst,
   input  logic [1:0]           in_outdir,
   input  logic [TAG_W-1:0]     in_tag,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [4:0]           out_prefer,
   output logic [4:0]           out_alt,
   output logic                 out_err,
   output logic [TAG_W-1:0]     out_tag,
   output logic                 err_sticky,
   output logic [7:0]           err_cnt
);

   route_t     in_route;
   buf_state_e state_q, state_d;
   logic       in_ready_q, in_ready_d;
   route_t     r0_q, r0_d, r1_q, r1_d;        // entry 0 is the head presented on the outputs
   logic [TAG_W-1:0] t0_q, t0_d, t1_q, t1_d;
   logic       err_sticky_q, err_sticky_d;
   logic [7:0] err_cnt_q, err_cnt_d;
   logic       acc;
   logic       con;

   rc_compute #(
      .MESH_X    (MESH_X),
      .MESH_Y    (MESH_Y),
      .COORD_W   (COORD_W),
      .CURR_X    (CURR_X),
      .CURR_Y    (CURR_Y),
      .MODE      (MODE),
      .LOOKAHEAD (LOOKAHEAD)
   ) u_compute (
      .dst    (in_dst),
      .outdir (in_outdir),
      .route  (in_route)
   );

   assign acc        = in_valid && in_ready_q;
   assign con        = out_valid && out_ready;
   assign in_ready   = in_ready_q;
   assign out_valid  = (state_q != BUF_EMPTY);
   assign out_prefer = r0_q.prefer;
   assign out_alt    = r0_q.alt;
   assign out_err    = r0_q.err;
   assign out_tag    = t0_q;
   assign err_sticky = err_sticky_q;
   assign err_cnt    = err_cnt_q;

   // Occupancy FSM, entry load/shift and error statistics
   always_comb begin
      state_d      = state_q;
      r0_d         = r0_q;
      t0_d         = t0_q;
      r1_d         = r1_q;
      t1_d         = t1_q;
      err_sticky_d = err_sticky_q;
      err_cnt_d    = err_cnt_q;

      case (state_q)
         BUF_EMPTY: begin
            if (acc) begin
               r0_d    = in_route;
               t0_d    = in_tag;
               state_d = BUF_ONE;
            end
         end
         BUF_ONE: begin
            if (acc && con) begin
               r0_d = in_route;
               t0_d = in_tag;
            end else if (acc) begin
               r1_d    = in_route;
               t1_d    = in_tag;
               state_d = BUF_TWO;
            end else if (con) begin
               state_d = BUF_EMPTY;
            end
         end
         BUF_TWO: begin
            // in_ready is low here, so only a consume can happen
            if (con) begin
               r0_d    = r1_q;
               t0_d    = t1_q;
               state_d = BUF_ONE;
            end
         end
         default: state_d = BUF_EMPTY;
      endcase

      if (acc && in_route.err) begin
         err_sticky_d = 1'b1;
         if (err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
         end
      end

      in_ready_d = (state_d != BUF_TWO);
   end

   // State registers with synchronous reset that also drops any buffered results
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= BUF_EMPTY;
         in_ready_q   <= 1'b1;
         r0_q         <= '0;
         t0_q         <= '0;
         r1_q         <= '0;
         t1_q         <= '0;
         err_sticky_q <= 1'b0;
         err_cnt_q    <= 8'd0;
      end else begin
         state_q      <= state_d;
         in_ready_q   <= in_ready_d;
         r0_q         <= r0_d;
         t0_q         <= t0_d;
         r1_q         <= r1_d;
         t1_q         <= t1_d;
         err_sticky_q <= err_sticky_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_rc_pipe.sv
// Bench for rc_pipe: four instances (XY, YX, XY+lookahead, YX+lookahead at row 0) share one stimulus stream.
// Expected routes come from a coordinate-level reference function and are queued on acceptance.
// A monitor compares the queue head against every instance while results are presented.
module tb_rc_pipe;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [5:0] in_dst = '0;
   logic [1:0] in_outdir = '0;
   logic [7:0] in_tag = '0;

   logic       in_rdy [4];
   logic       o_vld  [4];
   logic       o_err  [4];
   logic       e_st   [4];
   logic [4:0] o_pref [4];
   logic [4:0] o_alt  [4];
   logic [7:0] o_tag  [4];
   logic [7:0] e_cnt  [4];

   int checks = 0;
   int failures = 0;

   // Reference configuration of each instance
   int m_mode [4] = '{0, 1, 0, 1};
   int m_la   [4] = '{0, 0, 1, 1};
   int m_cx   [4] = '{1, 1, 1, 1};
   int m_cy   [4] = '{2, 2, 2, 0};

   typedef struct packed {
      logic [3:0][10:0] r;     // {err, alt, prefer} per instance
      logic [7:0]       tag;
   } exp_t;

   exp_t exp_q[$];
   int   cnt_m [4];
   logic st_m  [4];
   logic p_acc;
   exp_t p_e;

   always #5 clk = ~clk;

   rc_pipe #(.MESH_X(4), .MESH_Y(4), .COORD_W(3), .CURR_X(1), .CURR_Y(2), .MODE(0), .LOOKAHEAD(0), .TAG_W(8)) u0 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[0]), .in_dst(in_dst),
      .in_outdir(in_outdir), .in_tag(in_tag), .out_valid(o_vld[0]), .out_ready(out_ready),
      .out_prefer(o_pref[0]), .out_alt(o_alt[0]), .out_err(o_err[0]), .out_tag(o_tag[0]),
      .err_sticky(e_st[0]), .err_cnt(e_cnt[0]));
   rc_pipe #(.MESH_X(4), .MESH_Y(4), .COORD_W(3), .CURR_X(1), .CURR_Y(2), .MODE(1), .LOOKAHEAD(0), .TAG_W(8)) u1 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[1]), .in_dst(in_dst),
      .in_outdir(in_outdir), .in_tag(in_tag), .out_valid(o_vld[1]), .out_ready(out_ready),
      .out_prefer(o_pref[1]), .out_alt(o_alt[1]), .out_err(o_err[1]), .out_tag(o_tag[1]),
      .err_sticky(e_st[1]), .err_cnt(e_cnt[1]));
   rc_pipe #(.MESH_X(4), .MESH_Y(4), .COORD_W(3), .CURR_X(1), .CURR_Y(2), .MODE(0), .LOOKAHEAD(1), .TAG_W(8)) u2 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[2]), .in_dst(in_dst),
      .in_outdir(in_outdir), .in_tag(in_tag), .out_valid(o_vld[2]), .out_ready(out_ready),
      .out_prefer(o_pref[2]), .out_alt(o_alt[2]), .out_err(o_err[2]), .out_tag(o_tag[2]),
      .err_sticky(e_st[2]), .err_cnt(e_cnt[2]));
   rc_pipe #(.MESH_X(4), .MESH_Y(4), .COORD_W(3), .CURR_X(1), .CURR_Y(0), .MODE(1), .LOOKAHEAD(1), .TAG_W(8)) u3 (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_rdy[3]), .in_dst(in_dst),
      .in_outdir(in_outdir), .in_tag(in_tag), .out_valid(o_vld[3]), .out_ready(out_ready),
      .out_prefer(o_pref[3]), .out_alt(o_alt[3]), .out_err(o_err[3]), .out_tag(o_tag[3]),
      .err_sticky(e_st[3]), .err_cnt(e_cnt[3]));

   task automatic check(string name, logic [31:0] act, logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h at %0t", name, act, expv, $time);
      end
   endtask

   // Reference: step to the reference point, then pick ports from coordinate deltas
   function automatic logic [10:0] ref_route(int d, int dx, int dy, int dir);
      int rx, ry;
      logic [4:0] xp, yp, pref, alt;
      logic xd, yd;
      rx = m_cx[d];
      ry = m_cy[d];
      if (m_la[d] != 0) begin
         if (dir == 0)      ry = ry + 1;
         else if (dir == 1) rx = rx + 1;
         else if (dir == 2) ry = ry - 1;
         else               rx = rx - 1;
      end
      if (dx >= 4 || dy >= 4 || rx < 0 || rx >= 4 || ry < 0 || ry >= 4) return {1'b1, 10'b0};
      xp = (dx > rx) ? 5'b00010 : 5'b01000;
      yp = (dy > ry) ? 5'b00001 : 5'b00100;
      xd = (dx != rx);
      yd = (dy != ry);
      alt = 5'b0;
      if (!xd && !yd) pref = 5'b10000;
      else if (m_mode[d] == 0) begin
         pref = xd ? xp : yp;
         if (xd && yd) alt = yp;
      end else begin
         pref = yd ? yp : xp;
         if (xd && yd) alt = xp;
      end
      return {1'b0, alt, pref};
   endfunction

   // Acceptance side: check error statistics, then queue the expected result of an accepted request
   always begin
      @(negedge clk);
      if (reset) begin
         for (int d = 0; d < 4; d++) begin
            cnt_m[d] = 0;
            st_m[d]  = 1'b0;
         end
      end else begin
         for (int d = 0; d < 4; d++) begin
            check("err_cnt", 32'(e_cnt[d]), 32'(cnt_m[d]));
            check("err_sticky", 32'(e_st[d]), 32'(st_m[d]));
         end
         p_acc = in_valid && in_rdy[0];
         if (p_acc) begin
            p_e.tag = in_tag;
            for (int d = 0; d < 4; d++) begin
               p_e.r[d] = ref_route(d, int'(in_dst[2:0]), int'(in_dst[5:3]), int'(in_outdir));
               if (p_e.r[d][10]) begin
                  if (cnt_m[d] < 255) cnt_m[d] = cnt_m[d] + 1;
                  st_m[d] = 1'b1;
               end
            end
         end
         #1;
         if (p_acc) exp_q.push_back(p_e);
      end
   end

   // Monitor: handshake signals follow queue occupancy; presented result matches queue head
   always @(negedge clk) begin
      if (reset) begin
         exp_q.delete();
      end else begin
         for (int d = 0; d < 4; d++) begin
            check("out_valid", 32'(o_vld[d]), 32'(exp_q.size() != 0));
            check("in_ready", 32'(in_rdy[d]), 32'(exp_q.size() < 2));
            if (exp_q.size() != 0 && o_vld[d]) begin
               check("route", 32'({o_err[d], o_alt[d], o_pref[d]}), 32'(exp_q[0].r[d]));
               check("tag", 32'(o_tag[d]), 32'(exp_q[0].tag));
            end
         end
         if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
      end
   end

   task automatic issue(int x, int y, int dir, logic [7:0] tag);
      int n;
      @(posedge clk); #1;
      in_valid  = 1'b1;
      in_dst    = {3'(y), 3'(x)};
      in_outdir = 2'(dir);
      in_tag    = tag;
      n = 0;
      @(negedge clk);
      while (!in_rdy[0] && n < 50) begin
         n++;
         @(negedge clk);
      end
      check("issue_accept", 32'(in_rdy[0]), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic check_zero(string name);
      for (int d = 0; d < 4; d++) begin
         check({name, "_vld"}, 32'(o_vld[d]), 32'(0));
         check({name, "_rdy"}, 32'(in_rdy[d]), 32'(1));
         check({name, "_fields"}, 32'({o_pref[d], o_alt[d], o_err[d], o_tag[d]}), 32'(0));
         check({name, "_errstat"}, 32'({e_st[d], e_cnt[d]}), 32'(0));
      end
   endtask

   initial begin
      int n;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check_zero("reset");
      out_ready = 1'b1;

      // Directed routes with known answers
      issue(3, 3, 1, 8'h11);
      @(negedge clk);
      check("r039_vld", 32'(o_vld[0]), 32'(1));
      check("r039_pref", 32'(o_pref[0]), 32'(5'b00010));
      check("r039_alt", 32'(o_alt[0]), 32'(5'b00001));
      issue(1, 2, 0, 8'h12);
      @(negedge clk);
      check("r040_local", 32'({o_pref[0], o_alt[0]}), 32'({5'b10000, 5'b00000}));
      issue(0, 3, 0, 8'h13);
      @(negedge clk);
      check("r040_yx", 32'({o_pref[1], o_alt[1]}), 32'({5'b00001, 5'b01000}));
      issue(2, 2, 1, 8'h14);
      @(negedge clk);
      check("r041_la_local", 32'(o_pref[2]), 32'(5'b10000));
      issue(2, 2, 2, 8'h15);
      @(negedge clk);
      check("r041_la_off", 32'({o_err[3], o_pref[3]}), 32'({1'b1, 5'b00000}));
      issue(5, 0, 0, 8'h16);
      @(negedge clk);
      check("r043_err", 32'({o_err[0], e_st[0], e_cnt[0]}), 32'({1'b1, 1'b1, 8'd1}));

      // Backpressure: two accepts fill the buffer, the third waits
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(1, 1, 0, 8'h21);
      issue(2, 3, 3, 8'h22);
      @(negedge clk);
      check("r042_full", 32'(in_rdy[0]), 32'(0));
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_dst   = {3'd0, 3'd3};
      in_tag   = 8'h23;
      repeat (3) @(posedge clk);
      #1 out_ready = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_rdy[0] && n < 20) begin
         n++;
         @(negedge clk);
      end
      check("r042_resume", 32'(in_rdy[0]), 32'(1));
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Reset with the buffer full discards both entries
      @(posedge clk); #1;
      out_ready = 1'b0;
      issue(3, 0, 1, 8'h31);
      issue(0, 0, 2, 8'h32);
      @(negedge clk);
      check("r044_full", 32'(in_rdy[0]), 32'(0));
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check_zero("r044");
      repeat (4) begin
         @(negedge clk);
         check("r044_stale", 32'(o_vld[0]), 32'(0));
      end

      // Randomized traffic with random backpressure; mostly in-range destinations
      for (int i = 0; i < 600; i++) begin
         @(posedge clk); #1;
         in_valid  = 1'($urandom_range(0, 1));
         in_dst    = {3'($urandom_range(0, 3)), 3'($urandom_range(0, 4))};
         in_outdir = 2'($urandom_range(0, 3));
         in_tag    = 8'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drain();

      // 300 back-to-back erroneous requests saturate the counter
      @(posedge clk); #1;
      in_valid = 1'b1;
      in_dst   = {3'd0, 3'd7};
      for (int i = 0; i < 300; i++) begin
         in_tag = 8'(i);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      drain();
      @(negedge clk);
      check("r043_sat", 32'({e_st[0], e_cnt[0]}), 32'({1'b1, 8'd255}));

      @(posedge clk); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/rc_pipe.md
RC_PIPE -- requirements
Module: rc_pipe

Interface
REQ-001 Parameter MESH_X, default 4: mesh columns; x coordinates 0..MESH_X-1.
REQ-002 Parameter MESH_Y, default 4: mesh rows; y coordinates 0..MESH_Y-1.
REQ-003 Parameter COORD_W, default 3: width of each coordinate field.
REQ-004 Parameter CURR_X / CURR_Y, default 0 / 0: this router's coordinates.
REQ-005 Parameter MODE, default 0: 0 = XY order, 1 = YX order.
REQ-006 Parameter LOOKAHEAD, default 0: 1 = compute the route for the neighbour selected by in_outdir.
REQ-007 Parameter TAG_W, default 8: sideband tag width, passed through untouched.
REQ-008 clk  input  1  sole clock; all state updates on the rising edge.
REQ-009 reset  input  1  synchronous, active-high reset.
REQ-010 in_valid  input  1  request present.
REQ-011 in_ready  output  1  block can accept a request this cycle.
REQ-012 in_dst  input  2*COORD_W  destination; [COORD_W-1:0] = x, [2*COORD_W-1:COORD_W] = y.
REQ-013 in_outdir  input  2  lookahead direction 0=N,1=E,2=S,3=W; ignored when LOOKAHEAD=0.
REQ-014 in_tag  input  TAG_W  sideband.
REQ-015 out_valid  output  1  result present.
REQ-016 out_ready  input  1  consumer accepts result.
REQ-017 out_prefer  output  5  one-hot preferred port; bit 0=N(y+1), 1=E(x+1), 2=S(y-1), 3=W(x-1), 4=local.
REQ-018 out_alt  output  5  second productive port, or zero.
REQ-019 out_err  output  1  per-result range error.
REQ-020 out_tag  output  TAG_W  tag of the result.
REQ-021 err_sticky  output  1  set by any accepted erroneous request.
REQ-022 err_cnt  output  8  saturating count of accepted erroneous requests.

Function
REQ-023 The reference point shall be (CURR_X,CURR_Y) when LOOKAHEAD=0, else the neighbour of the current router in direction in_outdir.
REQ-024 In MODE 0, out_prefer shall be E/W when dst_x differs from ref_x, else N/S when dst_y differs, else local.
REQ-025 In MODE 1, out_prefer shall be N/S when dst_y differs from ref_y, else E/W when dst_x differs, else local.
REQ-026 out_alt shall be the productive port of the non-preferred dimension when both dimensions differ, else 5'b0.
REQ-027 An error shall exist when dst_x>=MESH_X, dst_y>=MESH_Y, or the lookahead neighbour is off-mesh; out_prefer and out_alt shall then be 5'b0 and out_err shall be 1.
REQ-028 A request shall be accepted on in_valid&&in_ready, and a result consumed on out_valid&&out_ready.
REQ-029 Latency shall be exactly 1 cycle from acceptance to out_valid when the buffer is empty.
REQ-030 A 2-entry skid buffer shall use states EMPTY, ONE and TWO, with in_ready = (state!=TWO), registered.
REQ-031 Transitions: accept-only increments occupancy; consume-only decrements it; simultaneous accept and consume holds occupancy and shifts the entries.
REQ-032 Sustained throughput shall be 1 result/cycle with out_ready held high; order shall be strictly FIFO, with no loss or duplication.
REQ-033 Output fields shall stay stable while out_valid && !out_ready.
REQ-034 err_cnt shall saturate at 255, and err_sticky shall clear only on reset.

Reset
REQ-035 On reset: state=EMPTY, out_valid=0, in_ready=1 in the following cycle, out_prefer/out_alt=0, out_err=0, out_tag=0, err_sticky=0, err_cnt=0.
REQ-036 Reset asserted mid-traffic shall discard all buffered entries, and no result shall appear afterwards.

Structure
REQ-037 A shared package shall hold the port index constants (N,E,S,W,L), the MODE encodings and the buffer state encoding.
REQ-038 The combinational route function shall be one sub-module, rc_compute, instantiated once at the input, with the registered skid buffer in rc_pipe.

Verification (MESH 4x4, CURR (1,2), COORD_W=3)
REQ-039 MODE 0, dst (3,3) accepted at cycle t -> at t+1 out_valid=1, out_prefer=00010, out_alt=00001.
REQ-040 dst (1,2) -> out_prefer=10000, out_alt=00000; MODE 1, dst (0,3) -> out_prefer=00001, out_alt=01000.
REQ-041 LOOKAHEAD=1, outdir=E, dst (2,2) -> out_prefer=10000; outdir=S from CURR (1,0) -> out_err=1, out_prefer=0.
REQ-042 out_ready=0 with 3 back-to-back requests -> in_ready=0 after 2 accepts; on out_ready=1, results emerge in order with no loss.
REQ-043 dst (5,0) -> out_err=1, err_sticky=1, err_cnt=1; 300 erroneous requests -> err_cnt=255; reset -> all zero.
REQ-044 Reset while state=TWO -> out_valid=0 next cycle, in_ready=1 next cycle, and no stale result appears.
